uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx serializer between NUM_REQ byte sources, e.g. the rx echo path, a status reporter and a debug dump.
- Round-robin grants one byte at a time and drives the uart_tx data_in/valid inputs.
- Sequences each transfer against uart_tx's tx_ready: launch, wait for busy, wait for done.
- Sits between the requesters and uart_tx inside uart_top.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ.
- ACK_TIMEOUT, 16, max cycles to wait for tx_ready to fall after launch.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- tx_data  out  8  to uart_tx data_in.
- tx_valid  out  1  to uart_tx valid.
- tx_ready  in  1  from uart_tx; high = idle, can accept.
- grant_id  out  ID_W  index of the current/last granted requester.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky; tx_ready never dropped after a launch.

Behaviour:
- Reset (async, rst_n low) clears all outputs to 0; state=IDLE; round-robin pointer=0.
- Outputs are registered. Reset asserted mid-transfer aborts immediately; tx_valid drops in the same cycle (async).
- FSM states:
  - IDLE: if tx_ready=1 and any req_valid=1, pick the winner (round-robin search starting at ptr), then:
    - latch its byte into tx_data and set grant_id;
    - pulse req_ready[winner] in the next cycle;
    - go to LAUNCH.
  - IDLE with tx_ready=0: stay, no grant.
  - LAUNCH: tx_valid=1 for exactly 1 cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: on tx_ready=0, go to WAIT_DONE. If the counter reaches ACK_TIMEOUT with tx_ready still 1:
    - set timeout_err;
    - go to IDLE (the byte counts as dropped).
  - WAIT_DONE: on tx_ready=1, set ptr = grant_id+1 (wrap to 0 after NUM_REQ-1); go to IDLE.
- Latency:
  - req_valid seen in IDLE → req_ready and tx_valid both assert 1 cycle later, in the same cycle.
  - Back-to-back bytes: at least 1 IDLE cycle between a done and the next launch.
- Requester rules:
  - The requester must hold req_valid and req_data stable until it sees req_ready.
  - req_data is sampled only in the IDLE grant cycle, so later changes have no effect.
- Simultaneous requests: the lowest index at or after ptr wins.
  - Example with NUM_REQ=3, ptr=2, all valid: order is 2, 0, 1, 2, ...
- A req_valid drop before grant is allowed; that requester is simply skipped.
- timeout_err clears only on reset.
- The ptr update also happens on timeout, so a stuck transmitter cannot starve the other requesters.

Optional Feature:
- Macro UART_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index always wins; ptr logic is removed.
- Undefined (default): round-robin as above.
- FSM, handshake and timeout behaviour are identical in both cases.

Decomposition:
- Package uart_pkg holds the shared constants:
  - UART_DATA_W=8;
  - the FSM state encoding (IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3);
  - the default ACK_TIMEOUT.
- One sub-module, uart_rr_picker: combinational, takes req_valid and ptr, outputs the winner index and found.
  - It is also reused later by an rx-side distributor.

Test Plan:
- Single requester: req_valid[1]=1, data 0x5A, tx_ready model idle.
  - Expect req_ready[1] and tx_valid pulse 1 cycle later, tx_data=0x5A, grant_id=1.
  - busy is held until the model raises tx_ready after 10 bit-times.
- All three valid continuously, data 0x11/0x22/0x33.
  - Transmitted sequence is 0x11,0x22,0x33,0x11.
  - Each req_ready is a single cycle and one-hot.
- Same stimulus with UART_ARB_FIXED_PRIO_EN: sequence is 0x11,0x11,0x11.
- tx_ready held high after launch: after ACK_TIMEOUT=16 cycles, timeout_err=1 and state=IDLE.
  - The next request is still served.
- rst_n pulled low in WAIT_DONE: all outputs 0 immediately.
  - After release, the pending request is re-granted from ptr=0.
- tx_ready=0 while in IDLE with req_valid=1: no req_ready and no tx_valid until tx_ready returns to 1.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the tx arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int ACK_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_picker.sv
// ============================================================================
// Module      : uart_rr_picker
// Description : Combinational round-robin search: first valid index at or
//               after ptr, wrapping at NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  int w_idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    w_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!found && req_valid[w_idx]) begin
        winner = ID_W'(w_idx);
        found  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one uart_tx between NUM_REQ byte sources, one byte per
//               grant. Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index
//               priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_DATA_W-1:0]         tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int c_CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

  arb_state_t             r_state;
  logic [NUM_REQ-1:0]     r_req_ready;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic                   r_tx_valid;
  logic [ID_W-1:0]        r_grant_id;
  logic                   r_busy;
  logic                   r_timeout_err;
  logic [c_CNT_W-1:0]     r_cnt;

  logic [ID_W-1:0]        w_ptr;
  logic [ID_W-1:0]        w_winner;
  logic                   w_found;
  logic                   w_timeout;
  logic [UART_DATA_W-1:0] w_req_byte [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_byte[gi] = req_data[gi*UART_DATA_W +: UART_DATA_W];
    end
  endgenerate

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid (req_valid),
    .ptr       (w_ptr),
    .winner    (w_winner),
    .found     (w_found)
  );

  // WAIT_BUSY lasts at most ACK_TIMEOUT cycles with tx_ready still high
  assign w_timeout = (r_state == WAIT_BUSY) && tx_ready && (r_cnt == c_CNT_LAST);

`ifdef UART_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [ID_W-1:0] r_ptr;
  logic            w_ptr_adv;

  // Advance on timeout too, so a stuck transmitter cannot starve anyone
  assign w_ptr_adv = w_timeout || ((r_state == WAIT_DONE) && tx_ready);
  assign w_ptr     = r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_ptr_adv) begin
      r_ptr <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_req_ready   <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_req_ready <= '0;
      r_tx_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tx_ready && w_found) begin
            r_tx_data   <= w_req_byte[w_winner];
            r_grant_id  <= w_winner;
            r_req_ready <= NUM_REQ'(1) << w_winner;
            r_tx_valid  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_ready) begin
            r_state <= WAIT_DONE;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed bench for uart_tx_arbiter with a simple uart_tx
//               ready model and a launch scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam int BUSY_CYCLES = 40;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  logic model_rdy = 1'b1;
  logic model_stuck = 1'b0;
  logic hold_low = 1'b0;
  int   busy_cnt = 0;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (3),
    .ID_W        (2),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // uart_tx stand-in: accepts on valid while idle, then busy for 10 bit-times
  assign tx_ready = model_rdy && !hold_low;

  always @(posedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_rdy <= 1'b1;
    end else if (tx_valid && model_rdy && !model_stuck) begin
      model_rdy <= 1'b0;
      busy_cnt  <= BUSY_CYCLES;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every launch must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst_n && (tx_valid || req_ready != 3'b000)) begin
      if (sb.size() == 0) begin
        check("unexpected_launch", {28'd0, tx_valid, req_ready}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("launch_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("launch_req_ready", {29'd0, req_ready}, {29'd0, 3'b001 << mon_e.id});
        check("launch_tx_data", {24'd0, tx_data}, {24'd0, mon_e.data});
        check("launch_grant_id", {30'd0, grant_id}, {30'd0, mon_e.id});
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic [1:0] id);
    exp_t e;
    e.data = d;
    e.id   = id;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int limit, input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (req_ready == 3'b000 && k < limit);
    check(tag, {31'd0, req_ready != 3'b000}, 32'd1);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < limit);
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, {29'd0, req_ready}, 32'd0);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Single requester: launch and req_ready one cycle after request
    @(negedge clk);
    push(8'h5A, 2'd1);
    req_data  = 24'h005A00;
    req_valid = 3'b010;
    @(negedge clk);
    check("single_latency_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("single_latency_req_ready", {29'd0, req_ready}, 32'd2);
    req_valid = 3'b000;
    repeat (20) @(negedge clk);
    check("single_busy_held", {31'd0, busy}, 32'd1);
    check("single_grant_id", {30'd0, grant_id}, 32'd1);
    wait_idle(60, "single_done");

    // All three continuously valid, pointer from 0
    do_reset();
    req_data  = 24'h332211;
    push(8'h11, 2'd0);
    push(FIXED ? 8'h11 : 8'h22, FIXED ? 2'd0 : 2'd1);
    push(FIXED ? 8'h11 : 8'h33, FIXED ? 2'd0 : 2'd2);
    push(8'h11, 2'd0);
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) wait_grant(80, "all_grant");
    req_valid = 3'b000;
    wait_idle(60, "all_done");

    // Stuck transmitter: timeout after 16 WAIT_BUSY cycles
    model_stuck = 1'b1;
    req_data  = 24'h770000;
    push(8'h77, 2'd2);
    req_valid = 3'b100;
    wait_grant(5, "to_grant");
    req_valid = 3'b000;
    repeat (16) @(negedge clk);
    check("to_not_yet", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    check("to_err_set", {31'd0, timeout_err}, 32'd1);
    check("to_back_idle", {31'd0, busy}, 32'd0);
    model_stuck = 1'b0;

    // Pointer advanced past 2 on timeout: 0 wins over 1
    req_data  = 24'h005544;
    push(8'h44, 2'd0);
    push(FIXED ? 8'h44 : 8'h55, FIXED ? 2'd0 : 2'd1);
    req_valid = 3'b011;
    for (int i = 0; i < 2; i++) wait_grant(80, "post_to_grant");
    req_valid = 3'b000;
    wait_idle(60, "post_to_done");
    check("to_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset in WAIT_DONE, then re-grant from pointer 0
    req_data  = 24'h886600;
    push(FIXED ? 8'h66 : 8'h88, FIXED ? 2'd1 : 2'd2);
    req_valid = 3'b110;
    wait_grant(5, "abort_grant");
    repeat (10) @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("abort");
    push(8'h66, 2'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(100, "regrant");
    req_valid = 3'b000;
    wait_idle(60, "regrant_done");

    // tx_ready low in IDLE blocks any grant
    hold_low  = 1'b1;
    req_data  = 24'h000099;
    req_valid = 3'b001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("blocked", {28'd0, tx_valid, req_ready}, 32'd0);
    end
    push(8'h99, 2'd0);
    hold_low = 1'b0;
    wait_grant(5, "unblocked_grant");
    req_valid = 3'b000;
    wait_idle(60, "unblocked_done");

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
